// File: rtl/alu_ex_stage.sv
// rtl/alu_ex_stage.sv - nPower execute stage: ALU plus EX/MEM register with one-entry skid buffer
//
// Purpose:
//   Computes the ALU result and flags for the instruction held in ID/EX.
//   The result is stored in the EX/MEM register, which uses a valid/ready handshake.
//   A main register M drives the outputs. A skid register S catches one extra entry
//   so that in_ready can come straight from a flop.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             drop every entry held in the stage
//   in_valid/in_ready upstream handshake (in_ready is registered)
//   alu_op            4-bit operation code
//   src_a, src_b      operands
//   rd_in, wen_in     destination tag and write enable
//   out_valid/out_ready downstream handshake
//   result, zero, carry, ovf, illegal, rd_out, wen_out   EX/MEM entry fields

module alu_ex_stage #(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [RW-1:0]   rd_in,
  input  logic            wen_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            carry,
  output logic            ovf,
  output logic            illegal,
  output logic [RW-1:0]   rd_out,
  output logic            wen_out
);

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
    logic            carry;
    logic            ovf;
    logic            illegal;
    logic [RW-1:0]   rd;
    logic            wen;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1101;

  state_t state;
  entry_t m_q;
  entry_t s_q;
  entry_t new_entry;

  logic [XLEN:0] sum;
  logic [XLEN:0] diff;
  logic          accept;
  logic          drain;

  // Both adders are XLEN+1 bits wide. The top bit is the carry.
  // For subtraction, the top bit is set when no borrow occurs.
  assign sum  = {1'b0, src_a} + {1'b0, src_b};
  assign diff = {1'b0, src_a} + {1'b0, ~src_b} + {{XLEN{1'b0}}, 1'b1};

  always_comb begin
    new_entry         = '0;
    new_entry.rd      = rd_in;
    unique case (alu_op)
      OP_AND: new_entry.result = src_a & src_b;
      OP_OR:  new_entry.result = src_a | src_b;
      OP_XOR: new_entry.result = src_a ^ src_b;
      OP_ADD: begin
        new_entry.result = sum[XLEN-1:0];
        new_entry.carry  = sum[XLEN];
        new_entry.ovf    = (src_a[XLEN-1] == src_b[XLEN-1]) &&
                           (sum[XLEN-1] != src_a[XLEN-1]);
      end
      OP_SUB: begin
        new_entry.result = diff[XLEN-1:0];
        new_entry.carry  = diff[XLEN];
        // For a-b, overflow is possible only when the operand signs differ.
        new_entry.ovf    = (src_a[XLEN-1] != src_b[XLEN-1]) &&
                           (diff[XLEN-1] != src_a[XLEN-1]);
      end
      OP_SLT: new_entry.result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: new_entry.illegal = 1'b1;
    endcase
    new_entry.zero = (new_entry.result == '0);
    new_entry.wen  = wen_in & ~new_entry.illegal;
  end

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // The M/S occupancy is encoded as EMPTY/ONE/FULL.
  // out_valid and in_ready are registered copies of "M valid" and "S empty".
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      m_q       <= '0;
      m_q.zero  <= 1'b1;
      s_q       <= '0;
    end else if (flush) begin
      // Only the valid state is cleared. The output fields keep their last values.
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            m_q       <= new_entry;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (drain && accept) begin
            m_q <= new_entry;
          end else if (drain) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end else if (accept) begin
            s_q      <= new_entry;
            state    <= FULL;
            in_ready <= 1'b0;
          end
        end
        FULL: begin
          // in_ready is low here, so no new entry can arrive together with the drain.
          if (drain) begin
            m_q      <= s_q;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign result  = m_q.result;
  assign zero    = m_q.zero;
  assign carry   = m_q.carry;
  assign ovf     = m_q.ovf;
  assign illegal = m_q.illegal;
  assign rd_out  = m_q.rd;
  assign wen_out = m_q.wen;

endmodule

// File: tb/tb_alu_ex_stage.sv
// tb/tb_alu_ex_stage.sv - self-checking bench for alu_ex_stage against a FIFO-level reference model

module tb_alu_ex_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  rd_in;
  logic        wen_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        carry;
  logic        ovf;
  logic        illegal;
  logic [4:0]  rd_out;
  logic        wen_out;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        o;
    logic        ill;
    logic [4:0]  rd;
    logic        wen;
  } exp_t;

  exp_t q[$];

  alu_ex_stage #(.XLEN(32), .RW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .src_a(src_a), .src_b(src_b),
    .rd_in(rd_in), .wen_in(wen_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .ovf(ovf),
    .illegal(illegal), .rd_out(rd_out), .wen_out(wen_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference ALU built from signed and unsigned 64-bit arithmetic
  function automatic exp_t ref_alu(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] rd,
                                   input logic w);
    exp_t e;
    longint ua, ub, sa, sb, s;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.res = 32'd0; e.c = 1'b0; e.o = 1'b0; e.ill = 1'b0;
    case (op)
      4'd0:  e.res = a & b;
      4'd1:  e.res = a | b;
      4'd13: e.res = a ^ b;
      4'd2: begin
        e.res = 32'(ua + ub);
        e.c   = (ua + ub) > 64'hFFFF_FFFF;
        s     = sa + sb;
        e.o   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd6: begin
        e.res = 32'(ua - ub);
        e.c   = (ua >= ub);
        s     = sa - sb;
        e.o   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd7:  e.res = (sa < sb) ? 32'd1 : 32'd0;
      default: e.ill = 1'b1;
    endcase
    e.z   = (e.res == 32'd0);
    e.rd  = rd;
    e.wen = w & ~e.ill;
    return e;
  endfunction

  task automatic compare_outputs();
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check("in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      check("result", 64'(result), 64'(q[0].res));
      check("zero", 64'(zero), 64'(q[0].z));
      check("carry", 64'(carry), 64'(q[0].c));
      check("ovf", 64'(ovf), 64'(q[0].o));
      check("illegal", 64'(illegal), 64'(q[0].ill));
      check("rd_out", 64'(rd_out), 64'(q[0].rd));
      check("wen_out", 64'(wen_out), 64'(q[0].wen));
    end
  endtask

  // The stage is modelled as a 2-deep FIFO. in_ready means "fewer than 2 entries".
  task automatic cycle();
    exp_t e;
    bit   acc, drn, clr;
    e   = ref_alu(alu_op, src_a, src_b, rd_in, wen_in);
    clr = rst || flush;
    acc = in_valid && (q.size() < 2);
    drn = out_ready && (q.size() > 0);
    @(posedge clk);
    #1;
    if (clr) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    compare_outputs();
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic w);
    in_valid = v; alu_op = op; src_a = a; src_b = b; rd_in = rd; wen_in = w;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_result"}, 64'(result), 64'd0);
    check({tag, "_zero"}, 64'(zero), 64'd1);
    check({tag, "_carry"}, 64'(carry), 64'd0);
    check({tag, "_ovf"}, 64'(ovf), 64'd0);
    check({tag, "_illegal"}, 64'(illegal), 64'd0);
    check({tag, "_rd_out"}, 64'(rd_out), 64'd0);
    check({tag, "_wen_out"}, 64'(wen_out), 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [5];
    corners = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 4)];
    return $urandom();
  endfunction

  initial begin
    logic [3:0] legal_ops [6];
    legal_ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd13};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    cycle();
    rst = 1'b0;
    check_reset_values("reset");

    // Directed ALU cases. out_ready stays high, so each result shows one cycle later.
    out_ready = 1'b1;
    drive(1'b1, 4'd2, 32'h7FFF_FFFF, 32'd1, 5'd3, 1'b1);
    cycle();
    check("add_result", 64'(result), 64'h8000_0000);
    check("add_ovf", 64'(ovf), 64'd1);
    check("add_carry", 64'(carry), 64'd0);
    check("add_zero", 64'(zero), 64'd0);
    check("add_rd", 64'(rd_out), 64'd3);
    drive(1'b1, 4'd6, 32'd5, 32'd5, 5'd4, 1'b1);
    cycle();
    check("sub_result", 64'(result), 64'd0);
    check("sub_zero", 64'(zero), 64'd1);
    check("sub_carry", 64'(carry), 64'd1);
    drive(1'b1, 4'd7, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1);
    cycle();
    check("slt_result", 64'(result), 64'd1);
    drive(1'b1, 4'd13, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd6, 1'b1);
    cycle();
    check("xor_result", 64'(result), 64'h0F0F_F0F0);
    drive(1'b1, 4'hF, 32'h1234, 32'h5678, 5'd7, 1'b1);
    cycle();
    check("ill_illegal", 64'(illegal), 64'd1);
    check("ill_wen", 64'(wen_out), 64'd0);
    check("ill_result", 64'(result), 64'd0);
    check("ill_zero", 64'(zero), 64'd1);
    in_valid = 1'b0;
    cycle();

    // Stall scenario: 1+1 sits in M, 2+2 goes to S, and 3+3 waits until there is room.
    out_ready = 1'b0;
    drive(1'b1, 4'd2, 32'd1, 32'd1, 5'd1, 1'b1); cycle();
    drive(1'b1, 4'd2, 32'd2, 32'd2, 5'd2, 1'b1); cycle();
    check("stall_in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 4'd2, 32'd3, 32'd3, 5'd3, 1'b1); cycle();
    check("stall_hold_m", 64'(result), 64'd2);
    out_ready = 1'b1;
    cycle();
    check("drain_second", 64'(result), 64'd4);
    cycle();
    check("drain_third", 64'(result), 64'd6);
    in_valid = 1'b0;
    cycle();
    check("drain_empty", 64'(out_valid), 64'd0);

    // FULL followed by flush. The input presented on the flush edge must disappear.
    out_ready = 1'b0;
    drive(1'b1, 4'd2, 32'd1, 32'd2, 5'd1, 1'b1); cycle();
    drive(1'b1, 4'd2, 32'd3, 32'd4, 5'd2, 1'b1); cycle();
    flush = 1'b1;
    drive(1'b1, 4'd2, 32'd9, 32'd9, 5'd9, 1'b1); cycle();
    flush = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();

    // Reset while the stage holds one entry and the memory stage is stalled
    out_ready = 1'b0;
    drive(1'b1, 4'd2, 32'd10, 32'd10, 5'd8, 1'b1); cycle();
    in_valid = 1'b0;
    rst = 1'b1; cycle(); rst = 1'b0;
    check_reset_values("midrst");
    out_ready = 1'b1;
    drive(1'b1, 4'd2, 32'd20, 32'd22, 5'd11, 1'b1); cycle();
    check("post_rst_result", 64'(result), 64'd42);
    in_valid = 1'b0;
    cycle();

    // Randomized traffic compared against the FIFO model
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom()) : legal_ops[$urandom_range(0, 5)];
      drive(1'($urandom_range(0, 3) != 0), op, pick_operand(), pick_operand(),
            5'($urandom()), 1'($urandom()));
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      rst       = ($urandom_range(0, 150) == 0);
      cycle();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
